u_dmem: RTL and testbench

Data-memory responder on the core's sram1 data port. It accepts dat_a/dat_we/dat_wd/dat_re from the core and returns dat_rd one cycle later. Each byte lane has its own write enable and read enable. After every reset a zero-fill sequencer clears the whole array, and an error pulse flags out-of-range accesses. It sits at top level beside the instruction SRAM, wired directly to the core's data port.

---
 rtl/core_pkg.sv | 12 +
 rtl/u_dmem_bank.sv | 28 ++
 rtl/u_dmem.sv | 70 +++++++
 tb/tb_u_dmem.sv | 113 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the data-memory responder
package core_pkg;
  localparam int DMEM_AW = 10;
  typedef enum logic {DM_CLR, DM_RUN} dmem_st_t;
  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_B1 = 4'b0010;
  localparam logic [3:0] LANE_B2 = 4'b0100;
  localparam logic [3:0] LANE_B3 = 4'b1000;
  localparam logic [3:0] LANE_H0 = 4'b0011;
  localparam logic [3:0] LANE_H1 = 4'b1100;
  localparam logic [3:0] LANE_W  = 4'b1111;
endpackage

// File: rtl/u_dmem_bank.sv
// u_dmem_bank: one byte lane of data memory with a registered read-first port
module u_dmem_bank
  import core_pkg::*;
#(
  parameter int AW = DMEM_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_i,
  input  logic          ld_i,
  input  logic          zero_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wd_i,
  output logic [7:0]    rd_o
);
  logic [7:0] mem [2**AW];
  logic [7:0] rd_q;
  // array write; contents are cleared by the owner's sequencer, not by reset
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wd_i;
  end
  // read register samples the pre-write value, giving read-first collisions
  always_ff @(posedge clk) begin
    if (!rstn) rd_q <= 8'h00;
    else if (ld_i) rd_q <= zero_i ? 8'h00 : mem[addr_i];
  end
  assign rd_o = rd_q;
endmodule

// File: rtl/u_dmem.sv
// u_dmem: data-memory responder with zero-fill after reset and range error pulse
module u_dmem
  import core_pkg::*;
#(
  parameter int          AW   = DMEM_AW,
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic        rdy,
  output logic        err
);
  localparam int DEPTH = 2**AW;
  dmem_st_t      st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   off;
  logic [AW-1:0] addr;
  logic          in_rng, run, clr, acc, ld;
  logic          unused;
  assign off    = dat_a - BASE;
  assign in_rng = {1'b0, off} < 17'(4 * DEPTH);
  assign run    = st_q == DM_RUN;
  assign clr    = !run;
  assign acc    = |dat_we || |dat_re;
  assign ld     = run && |dat_re;
  assign addr   = clr ? cnt_q : off[AW+1:2];
  assign unused = &{1'b0, off[1:0]};
  assign rdy    = run;
  assign err    = err_q;
  // state, clear counter and error pulse registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q  <= DM_CLR;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // sweep every word during CLR, then settle in RUN until the next reset
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    err_d = acc && !(run && in_rng);
    if (clr) begin
      cnt_d = cnt_q + 1'b1;
      st_d  = cnt_q == AW'(DEPTH - 1) ? DM_RUN : DM_CLR;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    u_dmem_bank #(.AW(AW)) u_bank (
      .clk   (clk),
      .rstn  (rstn),
      .we_i  (clr || (run && in_rng && dat_we[i])),
      .ld_i  (ld),
      .zero_i(!in_rng || !dat_re[i]),
      .addr_i(addr),
      .wd_i  (clr ? 8'h00 : dat_wd[8*i+:8]),
      .rd_o  (dat_rd[8*i+:8])
    );
  end
endmodule

// File: tb/tb_u_dmem.sv
// tb_u_dmem: directed scoreboard bench for u_dmem
module tb_u_dmem;
  import core_pkg::*;
  localparam logic [15:0] B = 16'h1000;
  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] dat_a = '0;
  logic [3:0]  dat_we = '0;
  logic [31:0] dat_wd = '0;
  logic [3:0]  dat_re = '0;
  logic [31:0] dat_rd;
  logic        rdy, err;
  exp_t        exp_q [$];
  int          total = 0;
  int          passes = 0;

  u_dmem #(.AW(4), .BASE(B)) dut (
    .clk(clk), .rstn(rstn), .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
    .dat_re(dat_re), .dat_rd(dat_rd), .rdy(rdy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk_pop();
    exp_t e;
    e = exp_q.pop_front();
    total++;
    assert (dat_rd === e.rd) passes++;
    else $error("FAIL %s dat_rd got %h want %h", e.tag, dat_rd, e.rd);
    total++;
    assert (err === e.err) passes++;
    else $error("FAIL %s err got %b want %b", e.tag, err, e.err);
  endtask

  task automatic step(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [3:0] re, input logic [31:0] xrd, input logic xerr, input string tag);
    dat_a = a; dat_we = we; dat_wd = wd; dat_re = re;
    exp_q.push_back('{tag, xrd, xerr});
    @(posedge clk); #1;
    dat_a = '0; dat_we = '0; dat_wd = '0; dat_re = '0;
    chk_pop();
  endtask

  task automatic wait_rdy(input int start, input string tag);
    int n = start;
    while (!rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    assert (n === 16) passes++;
    else $error("FAIL %s clear cycles got %0d want %0d", tag, n, 16);
  endtask

  task automatic chk_reset(input string tag);
    exp_q.push_back('{tag, 32'h0, 1'b0});
    chk_pop();
    total++;
    assert (rdy === 1'b0) passes++;
    else $error("FAIL %s rdy got %b want 0", tag, rdy);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rstn = 1'b1;
    wait_rdy(0, "zero_fill_len");
    for (int i = 0; i < 16; i++) step(B + 16'(4 * i), 4'h0, 32'h0, LANE_W, 32'h0, 1'b0, "zero_fill_rd");
    step(B + 16'h8, LANE_W, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0, "wr_word");
    step(B + 16'h8, LANE_B0, 32'h000000AA, 4'h0, 32'h0, 1'b0, "wr_b0");
    step(B + 16'h8, 4'h0, 32'h0, LANE_W, 32'hDEADBEAA, 1'b0, "rd_word");
    step(B + 16'h8, 4'h0, 32'h0, LANE_H1, 32'hDEAD0000, 1'b0, "rd_h1");
    step(B + 16'h4, LANE_W, 32'h11223344, 4'h0, 32'hDEAD0000, 1'b0, "coll_prep");
    step(B + 16'h4, LANE_W, 32'h55667788, LANE_W, 32'h11223344, 1'b0, "coll_rd_first");
    step(B + 16'h4, 4'h0, 32'h0, LANE_W, 32'h55667788, 1'b0, "coll_new");
    step(16'h0FFC, LANE_W, 32'hFFFFFFFF, 4'h0, 32'h55667788, 1'b1, "oor_below");
    step(16'h1040, LANE_W, 32'hFFFFFFFF, 4'h0, 32'h55667788, 1'b1, "oor_above");
    step(16'h1040, 4'h0, 32'h0, LANE_W, 32'h0, 1'b1, "oor_rd");
    step(B, 4'h0, 32'h0, LANE_W, 32'h0, 1'b0, "oor_no_alias0");
    step(16'h103C, 4'h0, 32'h0, LANE_W, 32'h0, 1'b0, "oor_no_alias15");
    step(16'h103C, LANE_W, 32'h12345678, 4'h0, 32'h0, 1'b0, "last_wr");
    step(16'h103C, 4'h0, 32'h0, LANE_W, 32'h12345678, 1'b0, "last_rd");
    step(B + 16'h10, LANE_W, 32'hCAFEF00D, 4'h0, 32'h12345678, 1'b0, "hold_prep");
    step(B + 16'h10, 4'h0, 32'h0, LANE_W, 32'hCAFEF00D, 1'b0, "hold_rd");
    for (int i = 0; i < 5; i++) step(B, 4'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "hold_idle");
    step(B + 16'h14, LANE_W, 32'h9999AAAA, 4'h0, 32'hCAFEF00D, 1'b0, "hold_wr_only");
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset2");
    rstn = 1'b1;
    step(B, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0, "rel_idle1");
    step(B, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0, "rel_idle2");
    step(B, LANE_W, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1, "clr_access");
    wait_rdy(3, "clr_len2");
    step(B, 4'h0, 32'h0, LANE_W, 32'h0, 1'b0, "clr_ignored");
    step(B, LANE_W, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, "pre_rst_wr");
    step(B, 4'h0, 32'h0, LANE_W, 32'hFFFFFFFF, 1'b0, "pre_rst_rd");
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset3");
    rstn = 1'b1;
    wait_rdy(0, "clr_len3");
    step(B, 4'h0, 32'h0, LANE_W, 32'h0, 1'b0, "post_rst_rd");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
